noc_input_fifo: RTL and testbench
=================================

Name: noc_input_fifo

Overview:
Per-input-port flit buffer of a NoC switch. It accepts flits from the upstream link or neighbour and presents the head flit first-word-fall-through to the route and arbitration logic. It pops on the combinational read enable (`rd`) produced by the switch's read-enable stage. It returns one credit upstream per popped flit and tracks packet boundaries, so downstream logic knows whether the head flit is a header.

Parameters:
DATA_WIDTH, 64, flit payload width in bits (tail bit carried separately).
DEPTH, 8, flit slots; power of two, minimum 2.
AW, 3, pointer width = log2(DEPTH); count register is AW+1 bits.

Ports:
clk  input  1  switch clock; all state on rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  flit present on in_data this cycle.
in_data  input  DATA_WIDTH  incoming flit payload.
in_tail  input  1  incoming flit is last of its packet.
rd  input  1  pop request from the read-enable stage (combinational, same cycle).
head_data  output  DATA_WIDTH  payload of oldest stored flit.
head_tail  output  1  tail bit of oldest stored flit.
head_is_hdr  output  1  oldest stored flit is the first flit of a packet.
empty  output  1  no flits stored.
count  output  AW+1  flits stored, 0..DEPTH.
credit_out  output  1  one-cycle pulse per popped flit, to upstream credit counter.
err_ovf  output  1  sticky: write attempted while full without a simultaneous pop.
err_udf  output  1  sticky: rd asserted while empty.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values: rd_ptr=0, wr_ptr=0, count=0, empty=1, mid_pkt=0, credit_out=0, err_ovf=0, err_udf=0.
- head_data and head_tail are don't-care while empty. Bench must not check them when empty=1.
- Reset mid-packet discards all stored flits. No credits are returned for discarded flits; upstream is reset with the switch.
- Storage: DEPTH-entry register array.
  - head_data and head_tail are driven combinationally from mem[rd_ptr] (FWFT).
  - Pointers wrap modulo DEPTH naturally at AW bits.
- Push: push = in_valid && (count<DEPTH || pop). On push, mem[wr_ptr] <= {in_tail,in_data} and wr_ptr++.
- Pop: pop = rd && !empty. On pop, rd_ptr++.
- Count update:
  - count += push − pop.
  - empty is a registered flag equal to (count_next==0).
- Write latency: a flit written at edge N is visible on head_data after edge N, with empty=0 in cycle N+1. There is no same-cycle fall-through.
- Empty with in_valid && rd in the same cycle:
  - The write is accepted; the pop is ignored.
  - err_udf sets.
  - count becomes 1.
- Full with in_valid && rd in the same cycle: both are accepted, count stays DEPTH, and no error is flagged.
- Full with in_valid && !rd: the flit is dropped, err_ovf sets, and pointers and count are unchanged.
- Credit: credit_out <= pop (registered). It is high for exactly one cycle, in the cycle after each pop. Back-to-back pops give a continuous high.
- Packet tracking:
  - On pop: mid_pkt <= !head_tail.
  - head_is_hdr = !mid_pkt && !empty.
  - A single-flit packet (tail set on its only flit) leaves mid_pkt=0.
- Error flags are sticky until rst.

Optional Feature:
Macro NOC_INFIFO_STATS_EN.
- When defined, the block adds:
  - Output port pkt_count (32-bit): increments on each pop of a tail flit.
  - Output port flit_count (32-bit): increments on each pop.
  - Both saturate at 2^32−1, reset to 0, and are registered (update the cycle after the pop).
- When undefined, these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
1. Reset, then idle for 5 cycles -> empty=1, count=0, credit_out=0, err_ovf=0, err_udf=0, head_is_hdr=0.
2. Write 3 flits A,B,C (C tail) over cycles 0..2, then rd held cycles 4..6 ->
   - head_data is A,B,C in cycles 4,5,6.
   - head_is_hdr=1 in cycle 4 only, and 1 again after the C pop only if a new flit is present.
   - credit_out high in cycles 5..7.
   - count ends at 0.
3. Fill 8 flits, then in_valid with rd=0 -> count=8, flit dropped, err_ovf=1. Next cycle in_valid && rd -> count stays 8, new flit becomes the last entry, read order preserved across pointer wrap.
4. Empty FIFO with in_valid=1, rd=1 in the same cycle -> count=1, err_udf=1, credit_out stays 0, flit D visible on head_data the next cycle.
5. Assert rst mid-packet (count=5, mid_pkt=1), no clock edge -> count=0, empty=1, mid_pkt=0 immediately; a subsequent write shows head_is_hdr=1.
6. With NOC_INFIFO_STATS_EN: pop 10 flits forming 3 packets -> flit_count=10, pkt_count=3. Preload flit_count to 2^32−1 via force and pop -> flit_count holds 2^32−1.

Source files
------------

// File: rtl/noc_input_fifo.sv
// Per-input-port FWFT flit buffer for a NoC switch with credit return and packet tracking.
// Optional pop statistics (flit_count, pkt_count) are enabled by defining NOC_INFIFO_STATS_EN.
module noc_input_fifo #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AW         = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_tail,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_tail,
  output logic                  head_is_hdr,
  output logic                  empty,
  output logic [AW:0]           count,
`ifdef NOC_INFIFO_STATS_EN
  output logic [31:0]           pkt_count,
  output logic [31:0]           flit_count,
`endif
  output logic                  credit_out,
  output logic                  err_ovf,
  output logic                  err_udf
);

  localparam int unsigned ENTRY_W  = DATA_WIDTH + 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;
  logic [AW:0]        count_q;
  logic [AW:0]        count_next;
  logic               empty_q;
  logic               mid_pkt;
  logic               full;
  logic               push;
  logic               pop;

  // Pop wins a slot back on a full FIFO, so a simultaneous write still fits.
  always_comb begin
    full       = (count_q == FULL_CNT);
    pop        = rd && !empty_q;
    push       = in_valid && (!full || pop);
    count_next = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  // Head entry is presented straight from storage.
  always_comb begin
    {head_tail, head_data} = mem[rd_ptr];
    head_is_hdr            = !mid_pkt && !empty_q;
    empty                  = empty_q;
    count                  = count_q;
  end

  // Storage is not reset; contents are only observable while non-empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_tail, in_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      mid_pkt    <= 1'b0;
      credit_out <= 1'b0;
      err_ovf    <= 1'b0;
      err_udf    <= 1'b0;
    end else begin
      credit_out <= pop;
      count_q    <= count_next;
      empty_q    <= (count_next == '0);
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        mid_pkt <= !head_tail;
      end
      if (in_valid && full && !pop) begin
        err_ovf <= 1'b1;
      end
      if (rd && empty_q) begin
        err_udf <= 1'b1;
      end
    end
  end

`ifdef NOC_INFIFO_STATS_EN
  logic [31:0] flit_cnt_q;
  logic [31:0] pkt_cnt_q;

  // Saturating pop counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flit_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else if (pop) begin
      if (flit_cnt_q != '1) begin
        flit_cnt_q <= flit_cnt_q + 32'd1;
      end
      if (head_tail && (pkt_cnt_q != '1)) begin
        pkt_cnt_q <= pkt_cnt_q + 32'd1;
      end
    end
  end

  always_comb begin
    flit_count = flit_cnt_q;
    pkt_count  = pkt_cnt_q;
  end
`endif

endmodule

// File: tb/tb_noc_input_fifo.sv
// Self-checking bench for noc_input_fifo: directed vector table plus hand sequences
// for async reset mid-packet and (with NOC_INFIFO_STATS_EN) the statistics counters.
module tb_noc_input_fifo;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_tail;
  logic          rd;
  logic [DW-1:0] head_data;
  logic          head_tail;
  logic          head_is_hdr;
  logic          empty;
  logic [AW:0]   count;
  logic          credit_out;
  logic          err_ovf;
  logic          err_udf;
`ifdef NOC_INFIFO_STATS_EN
  logic [31:0]   pkt_count;
  logic [31:0]   flit_count;
`endif

  noc_input_fifo #(.DATA_WIDTH(DW), .DEPTH(8), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_tail     (in_tail),
    .rd          (rd),
    .head_data   (head_data),
    .head_tail   (head_tail),
    .head_is_hdr (head_is_hdr),
    .empty       (empty),
    .count       (count),
`ifdef NOC_INFIFO_STATS_EN
    .pkt_count   (pkt_count),
    .flit_count  (flit_count),
`endif
    .credit_out  (credit_out),
    .err_ovf     (err_ovf),
    .err_udf     (err_udf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          tl;
    logic          rd;
    logic          e_empty;
    int            e_cnt;
    logic [DW-1:0] e_head;
    logic          e_tail;
    logic          e_hdr;
    logic          e_cred;
    logic          e_ovf;
    logic          e_udf;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expectations describe the cycle in which the inputs are applied.
  task automatic v(input logic iv, input logic [DW-1:0] d, input logic tl, input logic r,
                   input logic e_empty, input int e_cnt, input logic [DW-1:0] e_head,
                   input logic e_tail, input logic e_hdr, input logic e_cred,
                   input logic e_ovf, input logic e_udf);
    vec_t x;
    x = '{iv, d, tl, r, e_empty, e_cnt, e_head, e_tail, e_hdr, e_cred, e_ovf, e_udf};
    vecs.push_back(x);
  endtask

  task automatic step(input logic iv, input logic [DW-1:0] d, input logic tl, input logic r);
    in_valid = iv;
    in_data  = d;
    in_tail  = tl;
    rd       = r;
    @(negedge clk);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_tail = 1'b0; rd = 1'b0;

    // Idle after reset
    for (int i = 0; i < 5; i++) v(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    // Three-flit packet A,B,C then drain
    v(1, 'hA, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0);
    v(1, 'hB, 0, 0, 0, 1, 'hA, 0, 1, 0, 0, 0);
    v(1, 'hC, 1, 0, 0, 2, 'hA, 0, 1, 0, 0, 0);
    v(0, 0,   0, 0, 0, 3, 'hA, 0, 1, 0, 0, 0);
    v(0, 0,   0, 1, 0, 3, 'hA, 0, 1, 0, 0, 0);
    v(0, 0,   0, 1, 0, 2, 'hB, 0, 0, 1, 0, 0);
    v(0, 0,   0, 1, 0, 1, 'hC, 1, 0, 1, 0, 0);
    v(0, 0,   0, 0, 1, 0, 0,   0, 0, 1, 0, 0);
    // Fill across the pointer wrap, overflow drop, full push+pop, drain
    v(1, 'h10, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k < 8; k++) v(1, DW'('h10 + k), k == 7, 0, 0, k, 'h10, 0, 1, 0, 0, 0);
    v(1, 'h20, 0, 0, 0, 8, 'h10, 0, 1, 0, 0, 0);
    v(1, 'h21, 1, 1, 0, 8, 'h10, 0, 1, 0, 1, 0);
    for (int j = 0; j < 7; j++) v(0, 0, 0, 1, 0, 8 - j, DW'('h11 + j), j == 6, 0, 1, 1, 0);
    v(0, 0, 0, 1, 0, 1, 'h21, 1, 1, 1, 1, 0);
    v(0, 0, 0, 0, 1, 0, 0,    0, 0, 1, 1, 0);
    // Write and read together while empty
    v(1, 'hD, 1, 1, 1, 0, 0,   0, 0, 0, 1, 0);
    v(0, 0,   0, 1, 0, 1, 'hD, 1, 1, 0, 1, 1);
    v(0, 0,   0, 0, 1, 0, 0,   0, 0, 1, 1, 1);
    v(0, 0,   0, 0, 1, 0, 0,   0, 0, 0, 1, 1);

    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      chk($sformatf("v%0d empty", i), 64'(empty), 64'(vecs[i].e_empty));
      chk($sformatf("v%0d count", i), 64'(count), 64'(vecs[i].e_cnt));
      chk($sformatf("v%0d hdr", i), 64'(head_is_hdr), 64'(vecs[i].e_hdr));
      chk($sformatf("v%0d credit", i), 64'(credit_out), 64'(vecs[i].e_cred));
      chk($sformatf("v%0d ovf", i), 64'(err_ovf), 64'(vecs[i].e_ovf));
      chk($sformatf("v%0d udf", i), 64'(err_udf), 64'(vecs[i].e_udf));
      if (!vecs[i].e_empty) begin
        chk($sformatf("v%0d head_data", i), head_data, vecs[i].e_head);
        chk($sformatf("v%0d head_tail", i), 64'(head_tail), 64'(vecs[i].e_tail));
      end
      in_valid = vecs[i].iv;
      in_data  = vecs[i].d;
      in_tail  = vecs[i].tl;
      rd       = vecs[i].rd;
    end
    step(0, 0, 0, 0);

    // Async reset mid-packet with no clock edge
    pulse_rst();
    for (int i = 0; i < 6; i++) step(1, DW'('h30 + i), 0, 0);
    step(0, 0, 0, 1);
    chk("mid count", 64'(count), 64'd5);
    chk("mid hdr", 64'(head_is_hdr), 64'd0);
    chk("mid head", head_data, 64'h31);
    chk("mid credit", 64'(credit_out), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst count", 64'(count), 64'd0);
    chk("arst empty", 64'(empty), 64'd1);
    chk("arst hdr", 64'(head_is_hdr), 64'd0);
    chk("arst credit", 64'(credit_out), 64'd0);
    #1 rst = 1'b0;
    step(1, 'h40, 0, 0);
    step(0, 0, 0, 0);
    chk("post count", 64'(count), 64'd1);
    chk("post hdr", 64'(head_is_hdr), 64'd1);
    chk("post head", head_data, 64'h40);

`ifdef NOC_INFIFO_STATS_EN
    pulse_rst();
    for (int i = 0; i < 10; i++) begin
      step(1, DW'(i), (i == 2) || (i == 5) || (i == 9), 0);
      step(0, 0, 0, 1);
    end
    step(0, 0, 0, 0);
    chk("flit_count", 64'(flit_count), 64'd10);
    chk("pkt_count", 64'(pkt_count), 64'd3);
    force dut.flit_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.flit_cnt_q;
    step(1, 'h55, 1, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("flit_count sat", 64'(flit_count), 64'hFFFF_FFFF);
    chk("pkt_count after sat", 64'(pkt_count), 64'd4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
